jk_bank_ctrl: RTL and testbench

Command-driven sequencer for a WIDTH-bit bank of JK flip-flops. It accepts one operation at a time over a valid/ready handshake. Each operation is translated into per-bit J/K drive for one or more clock edges, then the block signals completion. Ops cover clear, set, load, toggle, increment, decrement and shift, so register and counter sequences run through JK-based storage under one controller.

---
 rtl/jk_ctrl_pkg.sv | 15 +
 rtl/jk_bank.sv | 16 +
 rtl/jk_bank_ctrl.sv | 80 ++++++++
 tb/tb_jk_bank_ctrl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/jk_ctrl_pkg.sv
// jk_ctrl_pkg: op codes and FSM states shared by the JK bank controller.
package jk_ctrl_pkg;
  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_CLR  = 3'd1;
  localparam logic [2:0] OP_SET  = 3'd2;
  localparam logic [2:0] OP_LOAD = 3'd3;
  localparam logic [2:0] OP_TGL  = 3'd4;
  localparam logic [2:0] OP_INC  = 3'd5;
  localparam logic [2:0] OP_DEC  = 3'd6;
  localparam logic [2:0] OP_SHL  = 3'd7;
  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_DONE} state_t;
  function automatic logic is_repeat(input logic [2:0] op);
    return op[2];
  endfunction
endpackage

// File: rtl/jk_bank.sv
// jk_bank: WIDTH independent JK flip-flops with asynchronous active-low reset.
module jk_bank #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_b
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) q <= '0;
    else q <= (j & ~q) | (~k & q);
  assign q_b = ~q;
endmodule

// File: rtl/jk_bank_ctrl.sv
// jk_bank_ctrl: command sequencer translating ops into per-edge J/K drive for a JK bank.
module jk_bank_ctrl
  import jk_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_b,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic             busy,
  output logic             done
);
  state_t state, state_nxt;
  logic [2:0] op_r;
  logic [WIDTH-1:0] data_r, jd, kd, shl_nxt;
  logic [CNT_W-1:0] rem;
  logic accept;
  assign cmd_ready = state == ST_IDLE;
  assign accept = cmd_valid & cmd_ready;
  assign busy = state != ST_IDLE;
  assign done = state == ST_DONE;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= ST_IDLE;
      op_r <= OP_NOP;
      data_r <= '0;
      rem <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_r <= cmd_op;
        data_r <= cmd_data;
        rem <= cmd_count;
      end else if (state == ST_EXEC) rem <= rem - CNT_W'(1);
    end
  always_comb begin
    state_nxt = state;
    if (state == ST_IDLE)
      state_nxt = !accept ? ST_IDLE : (is_repeat(cmd_op) && cmd_count == '0) ? ST_DONE : ST_EXEC;
    else if (state == ST_EXEC)
      state_nxt = (!is_repeat(op_r) || rem == CNT_W'(1)) ? ST_DONE : ST_EXEC;
    else
      state_nxt = ST_IDLE;
  end
  // Counter toggle masks: the bits that differ between q and q+/-1 are exactly the JK toggles.
  assign shl_nxt = {q[WIDTH-2:0], data_r[0]};
  always_comb begin
    jd = '0;
    kd = '0;
    case (op_r)
      OP_CLR:  kd = '1;
      OP_SET:  jd = '1;
      OP_LOAD: begin jd = data_r; kd = ~data_r; end
      OP_TGL:  begin jd = data_r; kd = data_r; end
      OP_INC:  begin jd = q ^ (q + WIDTH'(1)); kd = q ^ (q + WIDTH'(1)); end
      OP_DEC:  begin jd = q ^ (q - WIDTH'(1)); kd = q ^ (q - WIDTH'(1)); end
      OP_SHL:  begin jd = shl_nxt; kd = ~shl_nxt; end
      default: begin jd = '0; kd = '0; end
    endcase
  end
  assign j_out = state == ST_EXEC ? jd : '0;
  assign k_out = state == ST_EXEC ? kd : '0;
  jk_bank #(.WIDTH(WIDTH)) u_bank (
    .clk  (clk),
    .reset(reset),
    .j    (j_out),
    .k    (k_out),
    .q    (q),
    .q_b  (q_b)
  );
endmodule

// File: tb/tb_jk_bank_ctrl.sv
// tb_jk_bank_ctrl: directed self-checking bench for the JK bank controller.
module tb_jk_bank_ctrl;
  import jk_ctrl_pkg::*;
  localparam int W = 4;
  localparam int C = 8;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic cmd_valid = 1'b0;
  logic [2:0] cmd_op = 3'd0;
  logic [W-1:0] cmd_data = '0;
  logic [C-1:0] cmd_count = '0;
  logic cmd_ready, busy, done;
  logic [W-1:0] q, q_b, j_out, k_out;
  int checks = 0;
  int failures = 0;
  jk_bank_ctrl #(.WIDTH(W), .CNT_W(C)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_count(cmd_count),
    .q(q), .q_b(q_b), .j_out(j_out), .k_out(k_out), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [2:0] op, input logic [W-1:0] d, input logic [C-1:0] n);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_data = d;
    cmd_count = n;
    step();
    cmd_valid = 1'b0;
  endtask
  task automatic load(input logic [W-1:0] d);
    issue(OP_LOAD, d, 8'd0);
    step();
    step();
  endtask
  initial begin
    step();
    chk("rst_q", q, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    reset = 1'b1;
    step();
    chk("rel_ready", cmd_ready, 1'b1);
    // 1: asynchronous reset with q=1011
    load(4'b1011);
    chk("t1_pre_q", q, 4'b1011);
    #2 reset = 1'b0;
    #1;
    chk("t1_q", q, 4'b0000);
    chk("t1_qb", q_b, 4'b1111);
    chk("t1_busy", busy, 1'b0);
    #1 reset = 1'b1;
    step();
    chk("t1_ready", cmd_ready, 1'b1);
    // 2: LOAD 1010
    issue(OP_LOAD, 4'b1010, 8'd0);
    chk("t2_busy", busy, 1'b1);
    chk("t2_ready_lo", cmd_ready, 1'b0);
    chk("t2_j", j_out, 4'b1010);
    chk("t2_k", k_out, 4'b0101);
    step();
    chk("t2_q", q, 4'b1010);
    chk("t2_qb", q_b, 4'b0101);
    chk("t2_done", done, 1'b1);
    chk("t2_jidle", j_out, 4'b0000);
    step();
    chk("t2_done_lo", done, 1'b0);
    chk("t2_ready", cmd_ready, 1'b1);
    // 3: INC x3 across wrap
    load(4'b1110);
    issue(OP_INC, 4'b0000, 8'd3);
    chk("t3_j", j_out, 4'b0001);
    step();
    chk("t3_q1", q, 4'b1111);
    chk("t3_d1", done, 1'b0);
    step();
    chk("t3_q2", q, 4'b0000);
    chk("t3_d2", done, 1'b0);
    step();
    chk("t3_q3", q, 4'b0001);
    chk("t3_done", done, 1'b1);
    step();
    chk("t3_idle", busy, 1'b0);
    // 4: DEC x2 across wrap, then TGL count 0
    load(4'b0000);
    issue(OP_DEC, 4'b0000, 8'd2);
    step();
    chk("t4_q1", q, 4'b1111);
    step();
    chk("t4_q2", q, 4'b1110);
    chk("t4_done", done, 1'b1);
    step();
    issue(OP_TGL, 4'b0101, 8'd0);
    chk("t4_tgl0_done", done, 1'b1);
    chk("t4_tgl0_q", q, 4'b1110);
    chk("t4_tgl0_j", j_out, 4'b0000);
    step();
    chk("t4_tgl0_q2", q, 4'b1110);
    chk("t4_tgl0_ready", cmd_ready, 1'b1);
    // 5: SHL x4 with a second command held on the interface
    load(4'b0000);
    issue(OP_SHL, 4'b0001, 8'd4);
    cmd_valid = 1'b1;
    cmd_op = OP_LOAD;
    cmd_data = 4'b0100;
    cmd_count = 8'd0;
    step();
    chk("t5_q1", q, 4'b0001);
    step();
    chk("t5_q2", q, 4'b0011);
    step();
    chk("t5_q3", q, 4'b0111);
    step();
    chk("t5_q4", q, 4'b1111);
    chk("t5_done", done, 1'b1);
    chk("t5_ready_done", cmd_ready, 1'b0);
    step();
    chk("t5_idle_ready", cmd_ready, 1'b1);
    chk("t5_idle_q", q, 4'b1111);
    step();
    cmd_valid = 1'b0;
    chk("t5_acc_busy", busy, 1'b1);
    step();
    chk("t5_ld_q", q, 4'b0100);
    chk("t5_ld_done", done, 1'b1);
    step();
    // 6: reset aborts INC x10 after 4 steps
    load(4'b0000);
    issue(OP_INC, 4'b0000, 8'd10);
    step();
    step();
    step();
    step();
    chk("t6_q4", q, 4'b0100);
    #2 reset = 1'b0;
    #1;
    chk("t6_q", q, 4'b0000);
    chk("t6_busy", busy, 1'b0);
    chk("t6_done", done, 1'b0);
    step();
    #2 reset = 1'b1;
    step();
    chk("t6_ready", cmd_ready, 1'b1);
    chk("t6_nodone", done, 1'b0);
    chk("t6_q_hold", q, 4'b0000);
    issue(OP_LOAD, 4'b0110, 8'd0);
    step();
    chk("t6_ld_q", q, 4'b0110);
    chk("t6_ld_done", done, 1'b1);
    step();
    chk("t6_end_ready", cmd_ready, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
